// File: rtl/noc_arb_pkg.sv
// Shared constants for the NoC output-port arbiter: port count, pointer width,
// router port indices and FSM state encoding.
package noc_arb_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PTR_W     = 3;

  // Router input port indices, matching grant bit positions g00..g04
  localparam logic [PTR_W-1:0] LOCAL = 3'd0;
  localparam logic [PTR_W-1:0] NORTH = 3'd1;
  localparam logic [PTR_W-1:0] EAST  = 3'd2;
  localparam logic [PTR_W-1:0] SOUTH = 3'd3;
  localparam logic [PTR_W-1:0] WEST  = 3'd4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// Request/flit/grant bundle between the router input ports and one output arbiter.
// err_timeout exists only when NOC_ARB_TIMEOUT_EN is defined.
interface noc_output_arbiter_if #(
  parameter int unsigned NUM_PORTS = noc_arb_pkg::NUM_PORTS
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] flit_valid;
  logic [NUM_PORTS-1:0] flit_tail;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] grant;
  logic                 busy;
  logic                 xfer;
`ifdef NOC_ARB_TIMEOUT_EN
  logic                 err_timeout;
`endif

  // Requester / link side
  modport master (
    output req, flit_valid, flit_tail, out_ready,
    input  grant, busy, xfer
`ifdef NOC_ARB_TIMEOUT_EN
    , input err_timeout
`endif
  );

  // Arbiter side
  modport slave (
    input  req, flit_valid, flit_tail, out_ready,
    output grant, busy, xfer
`ifdef NOC_ARB_TIMEOUT_EN
    , output err_timeout
`endif
  );

endinterface

// File: rtl/noc_output_arbiter_rr_priority_pick.sv
// Combinational masked round-robin pick: ports at or above ptr win first,
// otherwise the lowest requesting port wins (wrap-around).
module rr_priority_pick #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PTR_W     = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] winner,
  output logic [PTR_W-1:0]     winner_idx
);

  logic             any_hi;
  logic             any_lo;
  logic [PTR_W-1:0] hi_idx;
  logic [PTR_W-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the last one written
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_lo = 1'b1;
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr) begin
          any_hi = 1'b1;
          hi_idx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    winner_idx = any_hi ? hi_idx : lo_idx;
    winner     = (any_hi || any_lo) ? (NUM_PORTS'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port round-robin arbiter with wormhole lock; grant drives g00..g04.
// Optional stall timeout enabled by defining NOC_ARB_TIMEOUT_EN.
module noc_output_arbiter #(
  parameter int unsigned NUM_PORTS = noc_arb_pkg::NUM_PORTS,
  parameter int unsigned PTR_W     = noc_arb_pkg::PTR_W
`ifdef NOC_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic                 clk,
  input logic                 rst,
  noc_output_arbiter_if.slave bus
);
  import noc_arb_pkg::*;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_nxt;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic                 busy_q;
  logic                 busy_nxt;
  logic [NUM_PORTS-1:0] win_oh;
  logic [PTR_W-1:0]     win_idx;
  logic                 xfer_c;
  logic                 tail_c;

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_q;
  logic             err_nxt;
`endif

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr),
    .winner     (win_oh),
    .winner_idx (win_idx)
  );

  assign xfer_c = (|(grant_q & bus.flit_valid)) & bus.out_ready;
  assign tail_c = |(grant_q & bus.flit_tail);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      grant_q <= grant_nxt;
      busy_q  <= busy_nxt;
`ifdef NOC_ARB_TIMEOUT_EN
      cnt     <= cnt_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  // Requests are only looked at in IDLE; LOCKED waits for the owner's tail
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant_q;
    busy_nxt  = busy_q;
`ifdef NOC_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
        if (|bus.req) begin
          state_nxt = ST_LOCKED;
          grant_nxt = win_oh;
          busy_nxt  = 1'b1;
          ptr_nxt   = (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (xfer_c && tail_c) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
`ifdef NOC_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
`ifdef NOC_ARB_TIMEOUT_EN
        else if (xfer_c) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Stall limit reached: drop the lock, keep the post-grant pointer
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.xfer  = xfer_c;
`ifdef NOC_ARB_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: vector table, hand sequences and
// randomized traffic against a packet-level reference model.
module tb_noc_output_arbiter;

  localparam int unsigned NP = 5;
`ifdef NOC_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_output_arbiter_if #(.NUM_PORTS(NP)) bus ();

  noc_output_arbiter #(
    .NUM_PORTS (NP),
    .PTR_W     (3)
`ifdef NOC_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner port (-1 = none), next-priority port, stall count
  int   m_owner;
  int   m_ptr;
  int   m_stall;
  logic m_err;

  typedef struct {
    logic [4:0] req;
    logic [4:0] valid;
    logic [4:0] tail;
    logic       rdy;
    logic [4:0] eg;
    logic       eb;
    logic       ex;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++) begin
      if (r[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [4:0] m_grant();
    return (m_owner >= 0) ? 5'(1 << m_owner) : 5'd0;
  endfunction

  function automatic logic m_xfer(input logic [4:0] v, input logic rdy);
    return (m_owner >= 0) && v[m_owner] && rdy;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t,
                            input logic rdy);
    int w;
    m_err = 1'b0;
    if (m_owner < 0) begin
      w = rr_pick(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % 5;
        m_stall = 0;
      end
    end else if (m_xfer(v, rdy)) begin
      m_stall = 0;
      if (t[m_owner]) m_owner = -1;
    end else begin
      m_stall++;
`ifdef NOC_ARB_TIMEOUT_EN
      if (m_stall >= int'(TO)) begin
        m_owner = -1;
        m_stall = 0;
        m_err   = 1'b1;
      end
`endif
    end
  endtask

  // Drive one cycle's inputs and compare outputs against the model
  task automatic apply(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t,
                       input logic rdy);
    @(negedge clk);
    bus.req        = r;
    bus.flit_valid = v;
    bus.flit_tail  = t;
    bus.out_ready  = rdy;
    #1;
    chk("model_grant", 32'(bus.grant), 32'(m_grant()));
    chk("model_busy",  32'(bus.busy),  32'(m_owner >= 0));
    chk("model_xfer",  32'(bus.xfer),  32'(m_xfer(v, rdy)));
`ifdef NOC_ARB_TIMEOUT_EN
    chk("model_err_timeout", 32'(bus.err_timeout), 32'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.req, bus.flit_valid, bus.flit_tail, bus.out_ready);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    bus.req        = '0;
    bus.flit_valid = '0;
    bus.flit_tail  = '0;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [4:0] eg;

    vecs[0]  = '{5'b10100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{5'b10100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1};
    vecs[2]  = '{5'b10100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1};
    vecs[3]  = '{5'b10100, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1, 1'b1};
    vecs[4]  = '{5'b10100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b1};
    vecs[5]  = '{5'b10100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
    vecs[6]  = '{5'b10100, 5'b10000, 5'b00000, 1'b0, 5'b10000, 1'b1, 1'b0};
    vecs[7]  = '{5'b00000, 5'b11111, 5'b10000, 1'b1, 5'b10000, 1'b1, 1'b1};
    vecs[8]  = '{5'b00100, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
    vecs[9]  = '{5'b00100, 5'b01011, 5'b01011, 1'b1, 5'b00100, 1'b1, 1'b0};
    vecs[10] = '{5'b00000, 5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 1'b1};
    vecs[11] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};

    rst            = 1'b0;
    bus.req        = '0;
    bus.flit_valid = '0;
    bus.flit_tail  = '0;
    bus.out_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    apply(5'b0, 5'b0, 5'b0, 1'b1);
    chk("reset_grant", 32'(bus.grant), 32'd0);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    tick();

    // Vector table: grant to port 2, 4-flit packet, bubble, then port 4
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].req, vecs[i].valid, vecs[i].tail, vecs[i].rdy);
      chk($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(vecs[i].eg));
      chk($sformatf("tbl%0d_busy", i),  32'(bus.busy),  32'(vecs[i].eb));
      chk($sformatf("tbl%0d_xfer", i),  32'(bus.xfer),  32'(vecs[i].ex));
      tick();
    end

    // Rotation with all ports requesting single-flit packets
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(5'b11111, 5'b11111, 5'b11111, 1'b1);
      chk($sformatf("rot%0d_bubble", k), 32'(bus.grant), 32'd0);
      tick();
      eg = 5'(1 << (k % 5));
      apply(5'b11111, 5'b11111, 5'b11111, 1'b1);
      chk($sformatf("rot%0d_grant", k), 32'(bus.grant), 32'(eg));
      chk($sformatf("rot%0d_xfer", k),  32'(bus.xfer),  32'd1);
      tick();
    end

    // Backpressure mid-packet
    do_reset();
    apply(5'b01000, 5'b00000, 5'b00000, 1'b1); tick();
    apply(5'b00000, 5'b01000, 5'b00000, 1'b1);
    chk("bp_first_xfer", 32'(bus.xfer), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(5'b00000, 5'b01000, 5'b01000, 1'b0);
      chk($sformatf("bp%0d_grant", k), 32'(bus.grant), 32'b01000);
      chk($sformatf("bp%0d_xfer", k),  32'(bus.xfer),  32'd0);
      tick();
    end
    apply(5'b00000, 5'b01000, 5'b01000, 1'b1);
    chk("bp_tail_xfer", 32'(bus.xfer), 32'd1);
    tick();
    apply(5'b00000, 5'b00000, 5'b00000, 1'b1);
    chk("bp_release_grant", 32'(bus.grant), 32'd0);
    chk("bp_release_busy",  32'(bus.busy),  32'd0);
    tick();

    // Reset while locked on port 3, then fresh arbitration from pointer 0
    do_reset();
    apply(5'b01000, 5'b00000, 5'b00000, 1'b1); tick();
    apply(5'b00000, 5'b00000, 5'b00000, 1'b1);
    chk("lock3_grant", 32'(bus.grant), 32'b01000);
    tick();
    do_reset();
    apply(5'b01001, 5'b00000, 5'b00000, 1'b1);
    chk("rst_lock_grant", 32'(bus.grant), 32'd0);
    chk("rst_lock_busy",  32'(bus.busy),  32'd0);
    tick();
    apply(5'b00000, 5'b00001, 5'b00001, 1'b1);
    chk("post_rst_grant0", 32'(bus.grant), 32'b00001);
    tick();
    apply(5'b01000, 5'b00000, 5'b00000, 1'b1); tick();
    apply(5'b00000, 5'b00000, 5'b00000, 1'b1); tick();
    do_reset();
    apply(5'b11000, 5'b00000, 5'b00000, 1'b1); tick();
    apply(5'b00000, 5'b01000, 5'b01000, 1'b1);
    chk("rst_ptr_zero_grant", 32'(bus.grant), 32'b01000);
    tick();

`ifdef NOC_ARB_TIMEOUT_EN
    // Owner stalls with no valid flit until the timeout forces release
    do_reset();
    apply(5'b00010, 5'b00000, 5'b00000, 1'b1); tick();
    for (int k = 0; k < int'(TO); k++) begin
      apply(5'b00000, 5'b00000, 5'b00000, 1'b1);
      chk($sformatf("to%0d_grant", k), 32'(bus.grant), 32'b00010);
      chk($sformatf("to%0d_err", k),   32'(bus.err_timeout), 32'd0);
      tick();
    end
    apply(5'b00000, 5'b00000, 5'b00000, 1'b1);
    chk("to_release_grant", 32'(bus.grant), 32'd0);
    chk("to_release_err",   32'(bus.err_timeout), 32'd1);
    tick();
    apply(5'b00000, 5'b00000, 5'b00000, 1'b1);
    chk("to_err_pulse_end", 32'(bus.err_timeout), 32'd0);
    tick();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [4:0] r, v, t;
      logic       rdy;
      r   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      v   = 5'($urandom);
      t   = 5'($urandom) & 5'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      apply(r, v, t, rdy);
      chk("rand_onehot", 32'($onehot0(bus.grant)), 32'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port round-robin arbiter with wormhole lock.
- Takes head-flit requests from the 5 router input ports and issues a registered one-hot grant.
- Holds the grant until the packet's tail flit transfers, then releases it.
- The grant vector drives the downstream output-port selector inputs g00..g04, which produce the crossbar mux select.

Parameters:
- NUM_PORTS, 5, number of requesting input ports; the grant width must match the selector, so 5 in this router.
- PTR_W, 3, width of the round-robin pointer; ceil(log2(NUM_PORTS)).
- TIMEOUT_CYCLES, 64, stall limit used only when NOC_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- req  input  NUM_PORTS  bit k: input port k has a head flit routed to this output.
- flit_valid  input  NUM_PORTS  bit k: input port k presents a valid flit this cycle.
- flit_tail  input  NUM_PORTS  bit k: the flit presented by port k is a tail flit (a single-flit packet has head and tail set).
- out_ready  input  1  downstream link/buffer can accept a flit this cycle.
- grant  output  NUM_PORTS  registered one-hot grant, or all zero; feeds g00..g04.
- busy  output  1  arbiter is in LOCKED.
- xfer  output  1  combinational: a flit moves this cycle.
- err_timeout  output  1  present only with NOC_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst==0 at a clk edge):
  - grant=0, busy=0, state=IDLE, pointer=0.
  - Timeout counter=0, err_timeout=0.
  - Applies mid-packet too: the lock is dropped with no tail required.
- States:
  - IDLE: if req!=0, pick the winner by round-robin starting at the pointer (pointer index has highest priority, then ascending with wrap NUM_PORTS-1 -> 0). Next cycle: grant=onehot(winner), busy=1, state=LOCKED, pointer=(winner+1) mod NUM_PORTS. If req==0: stay IDLE, grant stays 0.
  - LOCKED: grant and pointer hold. All req bits are ignored, including a drop of the owner's req.
- Latency: req asserted in cycle N in IDLE -> grant visible in cycle N+1.
- Transfer: xfer = |(grant & flit_valid) & out_ready.
  - With out_ready==0, nothing transfers and grant holds.
  - flit_valid of non-granted ports has no effect.
- Release:
  - xfer with the owner's flit_tail==1 -> next cycle grant=0, busy=0, state=IDLE.
  - Arbitration resumes in that IDLE cycle, so back-to-back packets on one output have a fixed one-cycle grant bubble.
- Simultaneous events:
  - Tail transfer while others request: new requests are evaluated in the following IDLE cycle, never in the tail cycle.
  - Tail and head on the same flit (single-flit packet): the lock lasts exactly one cycle when out_ready==1.
- Invariants:
  - grant is always one-hot or zero.
  - grant!=0 iff busy==1.
  - Pointer wrap: 4 -> 0 for NUM_PORTS=5.

Optional Feature:
- Macro NOC_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle without xfer and clears on xfer or on entering IDLE.
  - When it reaches TIMEOUT_CYCLES, the arbiter forces release: next cycle grant=0, state=IDLE, and err_timeout pulses high for one cycle.
  - The pointer keeps its post-grant value.
- Undefined: no counter and no err_timeout port; the lock is held indefinitely until the tail transfers.

Decomposition:
- Package noc_arb_pkg:
  - NUM_PORTS default.
  - Port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - State encoding IDLE/LOCKED.
  - Pointer width constant.
- One sub-module, rr_priority_pick: combinational masked round-robin pick. Inputs are req and pointer; outputs are one-hot winner and winner index. The top level owns all state.

Test Plan:
- Reset, then req=5'b10100 with pointer=0 -> grant=5'b00100 one cycle later, busy=1, pointer=3.
- Owner port 2 sends 4 flits (tail on the 4th) with out_ready=1 -> xfer asserted 4 cycles; the cycle after the tail, grant=0; the following cycle, grant=5'b10000.
- All req=5'b11111 held, single-flit packets -> grants rotate 00001, 00010, 00100, 01000, 10000, 00001, with one idle bubble between each.
- Mid-packet out_ready=0 for 3 cycles -> grant unchanged, xfer=0; the tail then transfers and the lock is released.
- rst=0 asserted while LOCKED on port 3 -> next cycle grant=0, busy=0, pointer=0; a subsequent req=5'b01001 is granted to port 0.
- NOC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, owner flit_valid=0 -> after 8 stalled cycles err_timeout pulses once and grant=0 the next cycle.
